ahb_sram_subordinate: RTL and testbench
=======================================

// Module: ahb_sram_subordinate
// PURPOSE
//  AHB-Lite subordinate that answers the ahb_manager_if manager: single-port word SRAM
//  (flop array) behind the standard address/data-phase pipeline. Programmable wait
//  states, byte-lane writes via HWSTRB, two-cycle ERROR response for illegal accesses.
//  Acts as the bench/system target memory for the AHB manager.
// PARAMETERS
//  ADDR_WIDTH   32   HADDR width
//  DATA_WIDTH   32   HWDATA/HRDATA width (32 or 64)
//  MEM_DEPTH    256  number of DATA_WIDTH words; byte window = MEM_DEPTH*DATA_WIDTH/8 from 0
//  WAIT_STATES  0    HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
// PORTS
//  HCLK       in   1             bus clock, all logic on rising edge
//  HRESET     in   1             asynchronous, active-high reset
//  HSEL       in   1             subordinate select (address phase)
//  HREADY     in   1             bus ready; high = previous transfer completing
//  HADDR      in   ADDR_WIDTH    byte address (address phase)
//  HTRANS     in   2             0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  HWRITE     in   1             1 write, 0 read
//  HSIZE      in   3             log2 bytes per beat
//  HBURST     in   3             burst type; ignored (each beat handled independently)
//  HMASTLOCK  in   1             ignored
//  HWDATA     in   DATA_WIDTH    write data (data phase)
//  HWSTRB     in   DATA_WIDTH/8  byte-lane write strobes (data phase)
//  HREADYOUT  out  1             subordinate ready
//  HRESP      out  1             0 OKAY, 1 ERROR
//  HRDATA     out  DATA_WIDTH    read data, valid in the cycle HREADYOUT=1 of a read
// BEHAVIOUR
//  - Reset (async assert): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0,
//    pending write dropped. Memory contents are NOT reset.
//  - Transfer accepted at a rising edge where HSEL & HREADY & HTRANS[1]. IDLE/BUSY or
//    unselected: no action; next cycle OKAY with zero wait (HREADYOUT=1, HRESP=0).
//  - Address phase registers: addr, write, size, lane mask = HSIZE/HADDR[low] bytes.
//  - Illegal = addr >= byte window, or HSIZE > log2(DATA_WIDTH/8), or addr not aligned
//    to HSIZE. Illegal transfers never touch memory.
//  - FSM: IDLE -> (legal, WAIT_STATES>0) WAIT -> DATA; IDLE -> (legal, 0 waits) DATA;
//    IDLE -> (illegal) ERR1 -> ERR2. DATA/ERR2 accept a new transfer same edge
//    (back-to-back pipelining), else return to IDLE.
//  - WAIT: HREADYOUT=0, HRESP=0 for exactly WAIT_STATES cycles (counter), then DATA.
//  - DATA: HREADYOUT=1, HRESP=0. Write: mem bytes where (HWSTRB & lane mask) written
//    with HWDATA at the edge ending DATA. Read: HRDATA = full word at addr (all lanes).
//  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. A transfer presented
//    during ERR1 is ignored (HREADY=0); manager may cancel to IDLE.
//  - Read data registered: HRDATA loaded on the edge entering DATA; word index = addr
//    divided by DATA_WIDTH/8. HRDATA holds last value outside read data phases.
//  - Read-after-write hazard: if a read is entering DATA on the same edge a write to the
//    same word completes, HRDATA = merged(mem word, HWDATA, effective strobes).
//  - Reset mid-transfer: pending write discarded, bus returns to OKAY/ready immediately.
//  - Latency: zero-wait read = data in cycle after address phase; write commits 1 edge
//    after address phase + WAIT_STATES.
// TESTING
//  1 WAIT_STATES=0: write 0xDEADBEEF @0x10 HWSTRB=4'hF, read @0x10 back-to-back ->
//    HREADYOUT never low, HRDATA=0xDEADBEEF in read data phase (forwarding path).
//  2 Byte write HSIZE=0 @0x21 HWDATA=0x0000AB00 HWSTRB=4'h2 over word 0x11223344 ->
//    read @0x20 returns 0x1122AB44; HWSTRB=4'hF with HSIZE=0 @0x21 gives same result.
//  3 WAIT_STATES=3: NONSEQ read @0x4 -> HREADYOUT low exactly 3 cycles, then 1, HRESP=0.
//  4 Read @0x400 (MEM_DEPTH=256, out of window) -> ERR1 (RDY=0,RESP=1), ERR2
//    (RDY=1,RESP=1); misaligned HSIZE=2 @0x2 write -> same ERROR, memory unchanged.
//  5 HTRANS=BUSY / HSEL=0 with HADDR=0x8 HWRITE=1 -> OKAY zero-wait, no memory change.
//  6 Assert HRESET during WAIT of a write -> HREADYOUT=1, HRESP=0 async; target word
//    unchanged after reset release.

Source files
------------

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a flop-array word SRAM.
// Supports programmable wait states, byte-lane writes and a two-cycle ERROR response.
module ahb_sram_subordinate #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic                    HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] WINDOW = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);
  localparam logic [2:0] SIZE_MAX  = 3'(ADDR_LSB);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e             state_q;
  logic [3:0]         wait_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               write_q;
  logic [BYTES-1:0]   lane_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic               accept;
  logic               misalign;
  logic               illegal;
  logic [BYTES-1:0]   lane_mask;
  logic [BYTES-1:0]   eff_strb;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic               unused_inputs;

  assign unused_inputs = ^{HBURST, HMASTLOCK};

  always_comb begin
    accept = HSEL && HREADY && HTRANS[1] &&
             (state_q == StIdle || state_q == StData || state_q == StErr2);
    misalign = 1'b0;
    for (int i = 0; i < ADDR_LSB; i++) begin
      if (i < int'(HSIZE)) misalign = misalign | HADDR[i];
    end
    illegal = ({1'b0, HADDR} >= WINDOW) || (HSIZE > SIZE_MAX) || misalign;
    // A lane belongs to the beat when it falls in the same HSIZE-aligned chunk as HADDR.
    for (int b = 0; b < BYTES; b++) begin
      lane_mask[b] = (b >> HSIZE) == (int'(HADDR[ADDR_LSB-1:0]) >> HSIZE);
    end
  end

  always_comb begin
    eff_strb = HWSTRB & lane_q;
    rd_idx   = (state_q == StWait) ? idx_q : HADDR[ADDR_LSB +: IDX_W];
    rd_word  = mem[rd_idx];
    // Forward the write completing on this edge into a read entering its data phase.
    if (state_q == StData && write_q && idx_q == rd_idx) begin
      for (int b = 0; b < BYTES; b++) begin
        if (eff_strb[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      lane_q     <= '0;
      HREADYOUT  <= 1'b1;
      HRESP      <= 1'b0;
      HRDATA     <= '0;
    end else begin
      case (state_q)
        StWait: begin
          if (wait_cnt_q == 4'd0) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
            if (!write_q) HRDATA <= rd_word;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q   <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (accept) begin
            idx_q   <= HADDR[ADDR_LSB +: IDX_W];
            write_q <= HWRITE && !illegal;
            lane_q  <= lane_mask;
            if (illegal) begin
              state_q   <= StErr1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state_q    <= StWait;
              wait_cnt_q <= WAIT_INIT;
              HREADYOUT  <= 1'b0;
              HRESP      <= 1'b0;
            end else begin
              state_q   <= StData;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              if (!HWRITE) HRDATA <= rd_word;
            end
          end else begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Memory has no reset; writes land at the edge that ends the data phase.
  always_ff @(posedge HCLK) begin
    if (state_q == StData && write_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (eff_strb[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Randomized scoreboard bench: two subordinates (0 and 3 wait states) on a shared bus,
// checked against a byte-array memory model.
module tb_ahb_sram_subordinate;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = '0;
  int          sel = 0;

  logic        rdy0, resp0, rdy3, resp3;
  logic [31:0] rdata0, rdata3;
  logic        hsel0, hsel3, rdy_m, resp_m;
  logic [31:0] rdata_m;

  assign hsel0   = hsel && (sel == 0);
  assign hsel3   = hsel && (sel == 1);
  assign rdy_m   = (sel == 0) ? rdy0 : rdy3;
  assign resp_m  = (sel == 0) ? resp0 : resp3;
  assign rdata_m = (sel == 0) ? rdata0 : rdata3;

  always #5 clk = ~clk;

  ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HREADY(rdy0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HREADY(rdy3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
  );

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [2][1024];
  int          errors = 0;
  int          checks = 0;
  bit          mon_skip = 1'b0;
  logic [31:0] pend_wdata = '0;
  logic [3:0]  pend_strb = '0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    return (a < 32'd1024) && (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int base = int'(a & 32'h3FC);
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  // One AHB address phase; returns after the edge that accepts it.
  task automatic issue(input bit s, input logic [1:0] tr, input logic [31:0] a, input bit wr,
                       input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] sb);
    int n = 0;
    bit r;
    exp_t e;
    hsel = s; htrans = tr; haddr = a; hwrite = wr; hsize = sz;
    hwdata = pend_wdata; hwstrb = pend_strb;
    forever begin
      @(negedge clk);
      r = rdy_m;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 40) begin
        $display("FAIL bus_timeout: HREADYOUT stuck low, got 0 required 1");
        $fatal(1, "bus timeout");
      end
    end
    #1;
    pend_wdata = $urandom;
    pend_strb  = 4'($urandom);
    if (s && tr[1]) begin
      e.rd    = !wr;
      e.err   = !legal(a, sz);
      e.waits = e.err ? 1 : (sel == 0 ? 0 : 3);
      e.data  = model_word(sel, a);
      q.push_back(e);
      if (wr && !e.err) begin
        for (int k = 0; k < (1 << sz); k++) begin
          int byte_a = int'(a) + k;
          if (sb[byte_a % 4]) ref_mem[sel][byte_a] = wd[8*(byte_a % 4) +: 8];
        end
      end
      if (wr) begin
        pend_wdata = wd;
        pend_strb  = sb;
      end
    end
  endtask

  task automatic idle();
    issue(1'b0, 2'd0, 32'h0, 1'b0, 3'd2, 32'h0, 4'h0);
  endtask

  // Monitor: pops one expectation per completed data phase.
  initial begin
    bit   dph = 1'b0;
    int   low = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || mon_skip) begin
        dph = 1'b0;
        low = 0;
        continue;
      end
      if (dph) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_data_phase", 32'(q.size()), 32'd1);
          dph = 1'b0;
        end else if (!rdy_m) begin
          low++;
          chk(resp_m == q[0].err, "resp_during_wait", 32'(resp_m), 32'(q[0].err));
          if (low > 40) begin
            chk(1'b0, "wait_bound", 32'(low), 32'(q[0].waits));
            void'(q.pop_front());
            dph = 1'b0;
            low = 0;
          end
        end else begin
          e = q.pop_front();
          chk(resp_m == e.err, "resp_final", 32'(resp_m), 32'(e.err));
          chk(low == e.waits, "wait_cycles", 32'(low), 32'(e.waits));
          if (e.rd && !e.err) chk(rdata_m === e.data, "read_data", rdata_m, e.data);
          dph = 1'b0;
          low = 0;
        end
      end else begin
        chk(rdy_m && !resp_m, "idle_okay", {30'd0, rdy_m, resp_m}, 32'h2);
      end
      if (!dph) dph = hsel && htrans[1] && rdy_m;
    end
  end

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0]  sz = 3'($urandom_range(0, 2));
      logic [31:0] a  = ($urandom_range(0, 1023) >> sz) << sz;
      int          kind = $urandom_range(0, 19);
      if (kind == 0) a = 32'h400 + $urandom_range(0, 4095);
      else if (kind == 1 && sz != 0) a = a | 32'h1;
      else if (kind == 2) sz = 3'd3;
      issue($urandom_range(0, 9) != 0, 2'($urandom), a, 1'($urandom), sz, $urandom,
            4'($urandom));
    end
    idle();
  endtask

  initial begin
    logic [31:0] w;
    #1 rst = 1'b1;
    #13;
    chk(rdy0 && rdy3, "reset_hreadyout", {30'd0, rdy0, rdy3}, 32'h3);
    chk(!resp0 && !resp3, "reset_hresp", {30'd0, resp0, resp3}, 32'h0);
    chk(rdata0 == 32'h0, "reset_hrdata0", rdata0, 32'h0);
    chk(rdata3 == 32'h0, "reset_hrdata3", rdata3, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Fill both memories so every model byte is defined.
    for (int d = 0; d < 2; d++) begin
      sel = d;
      for (int i = 0; i < 256; i++) issue(1'b1, 2'd2, 32'(i * 4), 1'b1, 3'd2, $urandom, 4'hF);
      idle();
    end

    sel = 0;
    // Zero-wait write then read of the same word, back to back.
    issue(1'b1, 2'd2, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
    idle();
    chk(model_word(0, 32'h10) == 32'hDEADBEEF, "model_forward_word", model_word(0, 32'h10),
        32'hDEADBEEF);
    // Byte write into lane 1, with a matching and then a full strobe.
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 2'd2, 32'h20, 1'b1, 3'd2, 32'h11223344, 4'hF);
      issue(1'b1, 2'd2, 32'h21, 1'b1, 3'd0, 32'h0000AB00, (k == 0) ? 4'h2 : 4'hF);
      issue(1'b1, 2'd2, 32'h20, 1'b0, 3'd2, 32'h0, 4'h0);
      idle();
      chk(model_word(0, 32'h20) == 32'h1122AB44, "byte_lane_word", model_word(0, 32'h20),
          32'h1122AB44);
    end
    // Out-of-window read and misaligned word write, then verify word 0 intact.
    w = model_word(0, 32'h0);
    issue(1'b1, 2'd2, 32'h400, 1'b0, 3'd2, 32'h0, 4'h0);
    issue(1'b1, 2'd2, 32'h2, 1'b1, 3'd2, 32'h55555555, 4'hF);
    issue(1'b1, 2'd2, 32'h0, 1'b0, 3'd2, 32'h0, 4'h0);
    idle();
    chk(model_word(0, 32'h0) == w, "model_err_untouched", model_word(0, 32'h0), w);
    // BUSY and unselected transfers leave the memory alone.
    issue(1'b1, 2'd1, 32'h8, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF);
    issue(1'b0, 2'd2, 32'h8, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF);
    issue(1'b1, 2'd2, 32'h8, 1'b0, 3'd2, 32'h0, 4'h0);
    idle();
    run_random(300);

    sel = 1;
    issue(1'b1, 2'd2, 32'h4, 1'b0, 3'd2, 32'h0, 4'h0);
    issue(1'b1, 2'd2, 32'h400, 1'b0, 3'd2, 32'h0, 4'h0);
    idle();
    run_random(150);

    // Reset during the wait phase of a write on the 3-wait subordinate.
    w = model_word(1, 32'h30);
    mon_skip = 1'b1;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk) #1;
    htrans = 2'd0; hwdata = ~w; hwstrb = 4'hF;
    @(negedge clk);
    chk(!rdy3 && !resp3, "wait_before_reset", {30'd0, rdy3, resp3}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk(rdy3 && !resp3, "async_reset_okay", {30'd0, rdy3, resp3}, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    mon_skip = 1'b0;
    @(posedge clk) #1;
    pend_wdata = '0;
    pend_strb  = '0;
    issue(1'b1, 2'd2, 32'h30, 1'b0, 3'd2, 32'h0, 4'h0);
    idle();
    idle();

    chk(q.size() == 0, "scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
